// File: rtl/kcpsm6_io_pkg.sv
// Shared constants for the KCPSM6 I/O controller: register addresses,
// interrupt/timer bit positions and the interrupt sequencer states.
package kcpsm6_io_pkg;

    localparam logic [7:0] ADDR_LED     = 8'h00;
    localparam logic [7:0] ADDR_SWITCH  = 8'h01;
    localparam logic [7:0] ADDR_PEND    = 8'h02;
    localparam logic [7:0] ADDR_EN      = 8'h03;
    localparam logic [7:0] ADDR_RELOAD0 = 8'h04;
    localparam logic [7:0] ADDR_RELOAD1 = 8'h05;
    localparam logic [7:0] ADDR_RELOAD2 = 8'h06;
    localparam logic [7:0] ADDR_TCTRL   = 8'h07;

    localparam int TIMER_BIT      = 7;
    localparam int TCTRL_EN_BIT   = 0;
    localparam int TCTRL_AUTO_BIT = 1;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    // Implemented bits of IRQ_PEND / IRQ_EN: external sources plus the timer.
    function automatic logic [7:0] irq_mask(input int num_irq);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if ((i < num_irq) || (i == TIMER_BIT)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/kcpsm6_io_timer.sv
// Programmable interval timer: 3 reload bytes, a down counter, and a
// one-cycle expiry strobe used to set the timer pending bit.
module kcpsm6_io_timer
    import kcpsm6_io_pkg::*;
#(
    parameter int TIMER_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         reload_we,
    input  logic               tctrl_we,
    input  logic [7:0]         wdata,
    output logic [TIMER_W-1:0] reload,
    output logic [1:0]         tctrl,
    output logic               expire
);

    logic [TIMER_W-1:0] reload_r;
    logic [TIMER_W-1:0] count_r;
    logic               en_r;
    logic               auto_r;

    logic [TIMER_W-1:0] reload_nxt_s;
    logic [TIMER_W-1:0] count_nxt_s;
    logic               en_nxt_s;
    logic               auto_nxt_s;
    logic               run_s;
    logic               expire_s;

    // Next-state for reload bytes, control bits and the down counter.
    always_comb begin
        reload_nxt_s = reload_r;
        count_nxt_s  = count_r;
        en_nxt_s     = en_r;
        auto_nxt_s   = auto_r;
        run_s        = en_r;
        expire_s     = 1'b0;

        for (int i = 0; i < 3; i++) begin
            if (reload_we[i]) begin
                reload_nxt_s[8*i +: 8] = wdata;
            end else begin
                reload_nxt_s[8*i +: 8] = reload_r[8*i +: 8];
            end
        end

        // A control write that keeps the timer enabled lets it keep ticking;
        // one that disables it freezes the count this very edge.
        if (tctrl_we) begin
            en_nxt_s   = wdata[TCTRL_EN_BIT];
            auto_nxt_s = wdata[TCTRL_AUTO_BIT];
            run_s      = en_r & wdata[TCTRL_EN_BIT];
        end else begin
            run_s      = en_r;
        end

        if (tctrl_we && !en_r && wdata[TCTRL_EN_BIT]) begin
            count_nxt_s = reload_r;
        end else if (run_s) begin
            if (count_r == '0) begin
                expire_s = 1'b1;
                if (auto_nxt_s) begin
                    count_nxt_s = reload_r;
                end else begin
                    en_nxt_s    = 1'b0;
                    count_nxt_s = count_r;
                end
            end else begin
                count_nxt_s = count_r - TIMER_W'(1);
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Timer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            reload_r <= '0;
            count_r  <= '0;
            en_r     <= 1'b0;
            auto_r   <= 1'b0;
        end else begin
            reload_r <= reload_nxt_s;
            count_r  <= count_nxt_s;
            en_r     <= en_nxt_s;
            auto_r   <= auto_nxt_s;
        end
    end

    assign reload = reload_r;
    assign tctrl  = {auto_r, en_r};
    assign expire = expire_s;

endmodule

// File: rtl/kcpsm6_io_ctrl.sv
// KCPSM6 port-bus decoder: LED/switch registers, interval timer,
// interrupt pending/enable and the interrupt/interrupt_ack sequencer.
module kcpsm6_io_ctrl
    import kcpsm6_io_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int TIMER_W = 24
) (
    input  logic               iClk,
    input  logic               iReset,
    input  logic [7:0]         iPortId,
    input  logic [7:0]         iOutPort,
    input  logic               iWriteStrobe,
    input  logic               iKWriteStrobe,
    input  logic               iReadStrobe,
    output logic [7:0]         oInPort,
    output logic               oInterrupt,
    input  logic               iInterruptAck,
    input  logic [NUM_IRQ-1:0] iIrqSrc,
    input  logic [7:0]         iSwitch,
    output logic [7:0]         oLed
);

    localparam logic [7:0] PEND_MASK = irq_mask(NUM_IRQ);

    logic [7:0]         led_r;
    logic [7:0]         sw_meta_r;
    logic [7:0]         sw_sync_r;
    logic [NUM_IRQ-1:0] irq_dly_r;
    logic [NUM_IRQ-1:0] edge_r;
    logic [7:0]         pend_r;
    logic [7:0]         en_r;
    logic [7:0]         in_port_r;
    logic               int_r;
    irq_state_e         state_r;
    irq_state_e         state_nxt_s;

    logic               wr_s;
    logic [7:0]         wr_addr_s;
    logic               wr_led_s;
    logic               wr_pend_s;
    logic               wr_en_s;
    logic [2:0]         reload_we_s;
    logic               tctrl_we_s;
    logic [7:0]         set_s;
    logic [7:0]         clr_s;
    logic [7:0]         pend_nxt_s;
    logic [7:0]         rd_data_s;
    logic [TIMER_W-1:0] reload_s;
    logic [1:0]         tctrl_s;
    logic               expire_s;

    // The read strobe carries no information here: in_port is refreshed every cycle.
    logic               unused_read_strobe_s;
    assign unused_read_strobe_s = iReadStrobe;

    kcpsm6_io_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk       (iClk),
        .reset     (iReset),
        .reload_we (reload_we_s),
        .tctrl_we  (tctrl_we_s),
        .wdata     (iOutPort),
        .reload    (reload_s),
        .tctrl     (tctrl_s),
        .expire    (expire_s)
    );

    // Write decode: OUTPUT uses the full port id and wins over OUTPUTK,
    // which only sees the low nibble.
    always_comb begin
        wr_s = iWriteStrobe | iKWriteStrobe;
        if (iWriteStrobe) begin
            wr_addr_s = iPortId;
        end else begin
            wr_addr_s = {4'h0, iPortId[3:0]};
        end
        wr_led_s       = wr_s && (wr_addr_s == ADDR_LED);
        wr_pend_s      = wr_s && (wr_addr_s == ADDR_PEND);
        wr_en_s        = wr_s && (wr_addr_s == ADDR_EN);
        reload_we_s[0] = wr_s && (wr_addr_s == ADDR_RELOAD0);
        reload_we_s[1] = wr_s && (wr_addr_s == ADDR_RELOAD1);
        reload_we_s[2] = wr_s && (wr_addr_s == ADDR_RELOAD2);
        tctrl_we_s     = wr_s && (wr_addr_s == ADDR_TCTRL);
    end

    // Pending update: W1C clears first, then new events are OR-ed in so a
    // coincident set survives the clear.
    always_comb begin
        set_s                = 8'h00;
        set_s[NUM_IRQ-1:0]   = edge_r;
        set_s[TIMER_BIT]     = expire_s;
        if (wr_pend_s) begin
            clr_s = iOutPort & PEND_MASK;
        end else begin
            clr_s = 8'h00;
        end
        pend_nxt_s = ((pend_r & ~clr_s) | set_s) & PEND_MASK;
    end

    // Read mux; unmapped addresses return zero.
    always_comb begin
        case (iPortId)
            ADDR_LED:     rd_data_s = led_r;
            ADDR_SWITCH:  rd_data_s = sw_sync_r;
            ADDR_PEND:    rd_data_s = pend_r;
            ADDR_EN:      rd_data_s = en_r;
            ADDR_RELOAD0: rd_data_s = reload_s[7:0];
            ADDR_RELOAD1: rd_data_s = reload_s[15:8];
            ADDR_RELOAD2: rd_data_s = reload_s[23:16];
            ADDR_TCTRL:   rd_data_s = {6'b000000, tctrl_s};
            default:      rd_data_s = 8'h00;
        endcase
    end

    // Interrupt sequencer next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IRQ_IDLE: begin
                if ((pend_r & en_r) != 8'h00) begin
                    state_nxt_s = IRQ_REQ;
                end else begin
                    state_nxt_s = IRQ_IDLE;
                end
            end
            IRQ_REQ: begin
                if (iInterruptAck) begin
                    state_nxt_s = IRQ_SERVICE;
                end else begin
                    state_nxt_s = IRQ_REQ;
                end
            end
            IRQ_SERVICE: begin
                if (wr_pend_s) begin
                    state_nxt_s = IRQ_IDLE;
                end else begin
                    state_nxt_s = IRQ_SERVICE;
                end
            end
            default: state_nxt_s = IRQ_IDLE;
        endcase
    end

    // Switch synchroniser and registered IRQ source edge detection.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            sw_meta_r <= 8'h00;
            sw_sync_r <= 8'h00;
            irq_dly_r <= '0;
            edge_r    <= '0;
        end else begin
            sw_meta_r <= iSwitch;
            sw_sync_r <= sw_meta_r;
            irq_dly_r <= iIrqSrc;
            edge_r    <= iIrqSrc & ~irq_dly_r;
        end
    end

    // Processor-visible registers: LED, pending, enable and in_port.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            led_r     <= 8'h00;
            pend_r    <= 8'h00;
            en_r      <= 8'h00;
            in_port_r <= 8'h00;
        end else begin
            if (wr_led_s) begin
                led_r <= iOutPort;
            end
            if (wr_en_s) begin
                en_r <= iOutPort & PEND_MASK;
            end
            pend_r    <= pend_nxt_s;
            in_port_r <= rd_data_s;
        end
    end

    // Sequencer state and registered interrupt output.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_r <= IRQ_IDLE;
            int_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            int_r   <= (state_nxt_s == IRQ_REQ);
        end
    end

    assign oLed       = led_r;
    assign oInPort    = in_port_r;
    assign oInterrupt = int_r;

endmodule

// File: tb/tb_kcpsm6_io_ctrl.sv
// Self-checking bench for kcpsm6_io_ctrl: directed scenarios plus a
// randomized register-map run against a simple register-file model.
module tb_kcpsm6_io_ctrl;

    logic       iClk = 1'b0;
    logic       iReset;
    logic [7:0] iPortId;
    logic [7:0] iOutPort;
    logic       iWriteStrobe;
    logic       iKWriteStrobe;
    logic       iReadStrobe;
    logic [7:0] oInPort;
    logic       oInterrupt;
    logic       iInterruptAck;
    logic [3:0] iIrqSrc;
    logic [7:0] iSwitch;
    logic [7:0] oLed;

    int tests = 0;
    int fails = 0;

    // Reference model of the plain read/write registers.
    logic [7:0] m_led;
    logic [7:0] m_en;
    logic [7:0] m_sw;
    logic [7:0] m_rel [3];

    always #5 iClk = ~iClk;

    kcpsm6_io_ctrl #(.NUM_IRQ(4), .TIMER_W(24)) dut (
        .iClk          (iClk),
        .iReset        (iReset),
        .iPortId       (iPortId),
        .iOutPort      (iOutPort),
        .iWriteStrobe  (iWriteStrobe),
        .iKWriteStrobe (iKWriteStrobe),
        .iReadStrobe   (iReadStrobe),
        .oInPort       (oInPort),
        .oInterrupt    (oInterrupt),
        .iInterruptAck (iInterruptAck),
        .iIrqSrc       (iIrqSrc),
        .iSwitch       (iSwitch),
        .oLed          (oLed)
    );

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] port, input logic [7:0] data, input bit k);
        iPortId       = port;
        iOutPort      = data;
        iWriteStrobe  = !k;
        iKWriteStrobe = k;
        step();
        iWriteStrobe  = 1'b0;
        iKWriteStrobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] port, output logic [7:0] val);
        iPortId     = port;
        iReadStrobe = 1'b1;
        step();
        val         = oInPort;
        iReadStrobe = 1'b0;
    endtask

    // Write through the bus and mirror the effect in the model.
    task automatic mwr(input logic [7:0] port, input logic [7:0] data, input bit k);
        logic [7:0] a;
        a = k ? {4'h0, port[3:0]} : port;
        case (a)
            8'h00:   m_led    = data;
            8'h03:   m_en     = data & 8'h8F;
            8'h04:   m_rel[0] = data;
            8'h05:   m_rel[1] = data;
            8'h06:   m_rel[2] = data;
            default: ;
        endcase
        wr(port, data, k);
    endtask

    // Expected read value with pending and timer control idle (both zero).
    function automatic logic [7:0] mread(input logic [7:0] a);
        case (a)
            8'h00:   return m_led;
            8'h01:   return m_sw;
            8'h03:   return m_en;
            8'h04:   return m_rel[0];
            8'h05:   return m_rel[1];
            8'h06:   return m_rel[2];
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        logic [7:0] v;
        logic [7:0] a;
        logic [7:0] p;
        logic [7:0] d;
        int sel;
        bit kk;

        iReset = 1'b1; iPortId = 8'h00; iOutPort = 8'h00;
        iWriteStrobe = 1'b0; iKWriteStrobe = 1'b0; iReadStrobe = 1'b0;
        iInterruptAck = 1'b0; iIrqSrc = 4'h0; iSwitch = 8'h00;
        m_led = 8'h00; m_en = 8'h00; m_sw = 8'h00;
        m_rel[0] = 8'h00; m_rel[1] = 8'h00; m_rel[2] = 8'h00;
        step(); step();
        check("rst_inport", oInPort, 8'h00);
        check("rst_led", oLed, 8'h00);
        check("rst_int", {7'd0, oInterrupt}, 8'h00);
        iReset = 1'b0;

        // LED writes, OUTPUTK aliasing, both strobes, reads
        mwr(8'h00, 8'hA5, 1'b0); check("led_out", oLed, 8'hA5);
        mwr(8'h10, 8'h3C, 1'b1); check("led_outk", oLed, 8'h3C);
        rd(8'h00, v); check("rd_led", v, 8'h3C);
        rd(8'h20, v); check("rd_unmapped", v, 8'h00);
        iPortId = 8'h10; iOutPort = 8'h77; iWriteStrobe = 1'b1; iKWriteStrobe = 1'b1;
        step();
        iWriteStrobe = 1'b0; iKWriteStrobe = 1'b0;
        check("both_strobes", oLed, 8'h3C);

        // Switch synchroniser
        iSwitch = 8'h5A; m_sw = 8'h5A;
        step(); step();
        rd(8'h01, v); check("sw_5a", v, 8'h5A);
        iSwitch = 8'hC3;
        step();
        rd(8'h01, v); check("sw_sync_lag", v, 8'h5A);
        rd(8'h01, v); check("sw_c3", v, 8'hC3);
        m_sw = 8'hC3;

        // Auto-reload timer, reload 4: period 5, interrupt handshake
        mwr(8'h03, 8'h80, 1'b0);
        mwr(8'h04, 8'h04, 1'b0); mwr(8'h05, 8'h00, 1'b0); mwr(8'h06, 8'h00, 1'b0);
        wr(8'h07, 8'h03, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("tmr_req_%0d", k), {7'd0, oInterrupt}, (k >= 6) ? 8'h01 : 8'h00);
        end
        iInterruptAck = 1'b1; step(); iInterruptAck = 1'b0;
        check("tmr_ack", {7'd0, oInterrupt}, 8'h00);
        wr(8'h02, 8'h80, 1'b0);
        check("tmr_w1c", {7'd0, oInterrupt}, 8'h00);
        for (int k = 9; k <= 11; k++) begin
            step();
            check($sformatf("tmr_period_%0d", k), {7'd0, oInterrupt}, (k == 11) ? 8'h01 : 8'h00);
        end
        iInterruptAck = 1'b1; step(); iInterruptAck = 1'b0;
        check("tmr_ack2", {7'd0, oInterrupt}, 8'h00);
        wr(8'h07, 8'h00, 1'b0);
        wr(8'h02, 8'h80, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("tmr_idle", {7'd0, oInterrupt}, 8'h00);
        end
        rd(8'h02, v); check("tmr_pend_clr", v, 8'h00);
        rd(8'h07, v); check("tmr_tctrl_off", v, 8'h00);

        // One-shot timer, reload 2: single expiry three cycles after enable
        mwr(8'h03, 8'h00, 1'b0);
        mwr(8'h04, 8'h02, 1'b0);
        wr(8'h07, 8'h01, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            rd(8'h02, v);
            check($sformatf("oneshot_%0d", k), v, (k == 4) ? 8'h80 : 8'h00);
        end
        rd(8'h07, v); check("oneshot_dis", v, 8'h00);
        rd(8'h04, v); check("reload0_rd", v, mread(8'h04));
        wr(8'h02, 8'h80, 1'b0);
        rd(8'h02, v); check("oneshot_clr", v, 8'h00);

        // Reload 0: expires every cycle, so set beats the W1C clear
        mwr(8'h04, 8'h00, 1'b0);
        wr(8'h07, 8'h03, 1'b0);
        rd(8'h02, v); check("rl0_first", v, 8'h00);
        rd(8'h02, v); check("rl0_set", v, 8'h80);
        wr(8'h02, 8'h80, 1'b0);
        rd(8'h02, v); check("rl0_setwins", v, 8'h80);
        wr(8'h07, 8'h00, 1'b0);
        wr(8'h02, 8'h80, 1'b0);
        rd(8'h02, v); check("rl0_clr", v, 8'h00);

        // External sources 0 and 2 with en = 0x05
        mwr(8'h03, 8'h05, 1'b0);
        iIrqSrc = 4'b0101; step(); iIrqSrc = 4'b0000;
        step(); check("ext_lat2", {7'd0, oInterrupt}, 8'h00);
        step(); check("ext_lat3", {7'd0, oInterrupt}, 8'h01);
        iInterruptAck = 1'b1; step(); iInterruptAck = 1'b0;
        check("ext_ack", {7'd0, oInterrupt}, 8'h00);
        wr(8'h02, 8'h01, 1'b0); check("ext_w1c0", {7'd0, oInterrupt}, 8'h00);
        step(); check("ext_rereq", {7'd0, oInterrupt}, 8'h01);
        rd(8'h02, v); check("ext_pend2", v, 8'h04);
        iInterruptAck = 1'b1; step(); iInterruptAck = 1'b0;
        wr(8'h02, 8'h04, 1'b0);
        step(); step(); check("ext_idle", {7'd0, oInterrupt}, 8'h00);
        rd(8'h02, v); check("ext_pend_clr", v, 8'h00);

        // Source 1 edge coinciding with a W1C of bit 1
        mwr(8'h03, 8'h00, 1'b0);
        iIrqSrc = 4'b0010;
        wr(8'h02, 8'h02, 1'b0);
        step();
        rd(8'h02, v); check("coinc_input", v, 8'h02);
        wr(8'h02, 8'h02, 1'b0);
        rd(8'h02, v); check("w1c_held_src", v, 8'h00);
        iIrqSrc = 4'b0000; step();
        iIrqSrc = 4'b0010; step();
        wr(8'h02, 8'h02, 1'b0);
        step();
        rd(8'h02, v); check("coinc_setwins", v, 8'h02);
        wr(8'h02, 8'h02, 1'b0);
        iIrqSrc = 4'b0000; step();
        rd(8'h02, v); check("coinc_clr", v, 8'h00);

        // Randomized register-map traffic against the model
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 5));
            kk  = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                case (sel)
                    0:       a = 8'h00;
                    1:       a = 8'h03;
                    2:       a = 8'h04;
                    3:       a = 8'h05;
                    4:       a = 8'h06;
                    default: a = kk ? 8'($urandom_range(8, 15)) : 8'($urandom_range(8, 255));
                endcase
                if (kk) begin
                    p = {4'($urandom_range(0, 15)), a[3:0]};
                end else begin
                    p = a;
                end
                mwr(p, d, kk);
                check("rnd_led", oLed, m_led);
            end else begin
                if (kk) begin
                    p = 8'($urandom);
                end else begin
                    p = 8'($urandom_range(0, 7));
                end
                rd(p, v);
                check($sformatf("rnd_rd_%02h", p), v, mread(p));
            end
        end

        // Reset while an interrupt is being requested
        mwr(8'h00, 8'hFF, 1'b0);
        mwr(8'h04, 8'h10, 1'b0);
        wr(8'h07, 8'h01, 1'b0);
        mwr(8'h03, 8'h02, 1'b0);
        iIrqSrc = 4'b0010;
        step(); step(); step();
        check("pre_rst_int", {7'd0, oInterrupt}, 8'h01);
        check("pre_rst_led", oLed, 8'hFF);
        iReset = 1'b1; iIrqSrc = 4'b0000;
        step();
        check("rst_req_int", {7'd0, oInterrupt}, 8'h00);
        check("rst_req_led", oLed, 8'h00);
        check("rst_req_inport", oInPort, 8'h00);
        iReset = 1'b0;
        m_led = 8'h00; m_en = 8'h00;
        m_rel[0] = 8'h00; m_rel[1] = 8'h00; m_rel[2] = 8'h00;
        rd(8'h02, v); check("rst_pend", v, 8'h00);
        rd(8'h07, v); check("rst_tctrl", v, 8'h00);
        rd(8'h04, v); check("rst_reload", v, mread(8'h04));
        rd(8'h03, v); check("rst_en", v, mread(8'h03));
        step(); step();
        check("rst_int_stays", {7'd0, oInterrupt}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
